// File: rtl/combo_lock_ctrl.sv
// Combination lock sequencer: digit entry from SW/KEY[1], retry lockout, and code reprogramming.
// Defining LOCK_TIMEOUT_EN adds an auto-relock timer that returns OPEN to ENTRY after OPEN_CYC cycles.
module combo_lock_ctrl #(
    parameter int unsigned CODE_LEN    = 3,
    parameter logic [15:0] DEF_CODE    = 16'h0010,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned LOCKOUT_CYC = 50000000,
    parameter int unsigned OPEN_CYC    = 500000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] KEY,
    input  logic [3:0] SW,
    output logic [7:0] LED,
    output logic       unlocked,
    output logic       alarm
);

    localparam int unsigned CODE_W = 4 * CODE_LEN;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned TRY_W  = 2;
    localparam int unsigned LOCK_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    localparam logic [1:0] ST_ENTRY   = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_PROGRAM = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    // Elaboration-time parameter range checks
    if (CODE_LEN < 2 || CODE_LEN > 4) begin : g_bad_code_len
        $error("combo_lock_ctrl: CODE_LEN must be 2..4");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 3) begin : g_bad_max_tries
        $error("combo_lock_ctrl: MAX_TRIES must be 1..3");
    end
    if (LOCKOUT_CYC < 1 || OPEN_CYC < 1) begin : g_bad_cycles
        $error("combo_lock_ctrl: LOCKOUT_CYC and OPEN_CYC must be at least 1");
    end

    logic [1:0]        sync1_q, sync2_q, hist_q;
    logic [1:0]        stb_q, stb_d;
    logic              enter_stb, clear_stb;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              mis_q, mis_d;
    logic [TRY_W-1:0]  tries_q, tries_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] shadow_q, shadow_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]        cur_digit;
    logic              open_to_c;

    logic [7:0]        led_q, led_d;
    logic              unlocked_q, unlocked_d;
    logic              alarm_q, alarm_d;

    function automatic logic [3:0] therm(input logic [IDX_W-1:0] n);
        therm = 4'((5'd1 << n) - 5'd1);
    endfunction

    // Synchronizer plus history; idle level of the active-low keys is 1
    always_comb begin
        stb_d = hist_q & ~sync2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            hist_q  <= 2'b11;
            stb_q   <= 2'b00;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            stb_q   <= stb_d;
        end
    end

    // Clear/relock has priority over enter when both strobe together
    assign clear_stb = stb_q[0];
    assign enter_stb = stb_q[1] & ~stb_q[0];

`ifdef LOCK_TIMEOUT_EN
    localparam int unsigned OPEN_W = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;

    logic [OPEN_W-1:0] open_cnt_q, open_cnt_d;

    assign open_to_c = (state_q == ST_OPEN) && (open_cnt_q == OPEN_W'(OPEN_CYC - 1));

    // Counter idles at zero outside OPEN, so it is cleared on every entry to OPEN
    always_comb begin
        open_cnt_d = '0;
        if (state_q == ST_OPEN && stb_q == 2'b00 && !open_to_c) begin
            open_cnt_d = open_cnt_q + OPEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_cnt_q <= '0;
        end else begin
            open_cnt_q <= open_cnt_d;
        end
    end
`else
    assign open_to_c = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mis_d      = mis_q;
        tries_d    = tries_q;
        code_d     = code_q;
        shadow_d   = shadow_q;
        lock_cnt_d = lock_cnt_q;
        cur_digit  = 4'h0;

        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = code_q[4*i +: 4];
            end
        end

        case (state_q)
            ST_ENTRY: begin
                if (clear_stb) begin
                    idx_d = '0;
                    mis_d = 1'b0;
                end else if (enter_stb) begin
                    if (idx_q < IDX_W'(CODE_LEN - 1)) begin
                        idx_d = idx_q + IDX_W'(1);
                        if (SW != cur_digit) begin
                            mis_d = 1'b1;
                        end
                    end else begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (!mis_q && SW == cur_digit) begin
                            state_d = ST_OPEN;
                            tries_d = '0;
                        end else begin
                            tries_d = tries_q + TRY_W'(1);
                            if (tries_d == TRY_W'(MAX_TRIES)) begin
                                state_d    = ST_LOCKOUT;
                                lock_cnt_d = '0;
                            end
                        end
                    end
                end
            end
            ST_OPEN: begin
                if (clear_stb) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                end else if (enter_stb) begin
                    state_d = ST_PROGRAM;
                    idx_d   = '0;
                end else if (open_to_c) begin
                    state_d = ST_ENTRY;
                    idx_d   = '0;
                end
            end
            ST_PROGRAM: begin
                if (clear_stb) begin
                    state_d = ST_OPEN;
                    idx_d   = '0;
                end else if (enter_stb) begin
                    for (int unsigned i = 0; i < CODE_LEN; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shadow_d[4*i +: 4] = SW;
                        end
                    end
                    if (idx_q == IDX_W'(CODE_LEN - 1)) begin
                        code_d  = shadow_d;
                        state_d = ST_ENTRY;
                        idx_d   = '0;
                        mis_d   = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == LOCK_W'(LOCKOUT_CYC - 1)) begin
                    state_d    = ST_ENTRY;
                    tries_d    = '0;
                    lock_cnt_d = '0;
                    idx_d      = '0;
                    mis_d      = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
        endcase
    end

    // Outputs decoded from next-state values so they change on the same edge as the state
    always_comb begin
        led_d      = 8'h00;
        unlocked_d = 1'b0;
        alarm_d    = 1'b0;
        case (state_d)
            ST_ENTRY:   led_d = {2'b00, tries_d, therm(idx_d)};
            ST_OPEN: begin
                led_d      = 8'hFF;
                unlocked_d = 1'b1;
            end
            ST_PROGRAM: led_d = {4'b0100, therm(idx_d)};
            ST_LOCKOUT: begin
                led_d   = 8'h80;
                alarm_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ENTRY;
            idx_q      <= '0;
            mis_q      <= 1'b0;
            tries_q    <= '0;
            code_q     <= DEF_CODE[CODE_W-1:0];
            shadow_q   <= '0;
            lock_cnt_q <= '0;
            led_q      <= 8'h00;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mis_q      <= mis_d;
            tries_q    <= tries_d;
            code_q     <= code_d;
            shadow_q   <= shadow_d;
            lock_cnt_q <= lock_cnt_d;
            led_q      <= led_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    assign LED      = led_q;
    assign unlocked = unlocked_q;
    assign alarm    = alarm_q;

endmodule

// File: doc/combo_lock_ctrl.md
Name: combo_lock_ctrl

Overview:
Sequencing controller for the switch-entered combination lock. It takes digits from SW[3:0], confirmed one per press of KEY[1], and compares them against a stored multi-digit code. It counts failed attempts and forces a timed lockout after too many failures. While open, it lets the user program a new code. It sits between the board buttons/switches and the LED bank, in the same top level as the lock datapath.

Parameters:
CODE_LEN, 3, number of 4-bit digits in the code (2..4)
DEF_CODE, 16'h0010, code loaded at reset; digit i occupies bits [4i+3:4i], digit 0 entered first
MAX_TRIES, 3, failed attempts before lockout (1..3)
LOCKOUT_CYC, 50000000, lockout duration in clk cycles
OPEN_CYC, 500000000, auto-relock delay in cycles (used only with LOCK_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
KEY  input  2  active-low push buttons; KEY[1]=enter, KEY[0]=clear/relock
SW  input  4  digit value
LED  output  8  status display
unlocked  output  1  high only in OPEN
alarm  output  1  high only in LOCKOUT

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to ENTRY; digit index = 0; mismatch flag = 0; tries = 0; lockout/open counters = 0.
  - Stored code = DEF_CODE[4*CODE_LEN-1:0]; LED = 8'h00; unlocked = 0; alarm = 0.
- Button conditioning:
  - Each KEY bit passes through a 2-flop synchronizer plus a history flop.
  - A press strobe is one cycle wide and fires on the synced 1->0 transition.
  - A key held low produces exactly one strobe.
  - A KEY falling before clk edge N causes the state/output update at edge N+3.
- Simultaneous strobes: KEY[0] wins; the KEY[1] strobe is discarded.
- ENTRY:
  - KEY[1] strobe: if SW != code[idx], set mismatch. If idx < CODE_LEN-1, idx++.
  - Otherwise the code is complete:
    - mismatch clear (including the current digit) -> OPEN, tries = 0.
    - else tries++; if the new tries == MAX_TRIES -> LOCKOUT, else remain in ENTRY.
    - In both cases idx = 0 and mismatch = 0.
  - There is no early abort on a wrong digit. The failing position is never revealed.
  - KEY[0] strobe: idx = 0, mismatch = 0; tries unchanged.
  - LED[3:0] = thermometer of digits entered (idx ones). LED[5:4] = tries. LED[7:6] = 0.
- OPEN:
  - LED = 8'hFF; unlocked = 1.
  - KEY[0] strobe -> ENTRY.
  - KEY[1] strobe -> PROGRAM with idx = 0.
- PROGRAM:
  - KEY[1] strobe writes SW into a shadow digit idx and increments idx.
  - On the CODE_LEN-th digit, the shadow is copied into the stored code in the same cycle, then -> ENTRY (locked).
  - KEY[0] strobe aborts -> OPEN; stored code unchanged; shadow discarded.
  - LED[6] = 1; LED[3:0] = thermometer of idx; other LED bits 0.
- LOCKOUT:
  - alarm = 1; LED = 8'h80; all strobes ignored.
  - The counter runs 0..LOCKOUT_CYC-1. On the cycle it reaches LOCKOUT_CYC-1: -> ENTRY, tries = 0, counter = 0.
  - The counter is sized to $clog2(LOCKOUT_CYC).
- LED, unlocked and alarm are registered, and are updated in the same edge as the state.
- Reset mid-operation, in any state including PROGRAM, restores DEF_CODE. A partially programmed code is lost.

Optional Feature:
Macro LOCK_TIMEOUT_EN.
- Defined: in OPEN, an open counter increments each cycle. When it reaches OPEN_CYC-1 with no strobe, the FSM returns to ENTRY. Any strobe in OPEN clears the counter. The counter is also cleared on entry to OPEN.
- Undefined: OPEN persists until a KEY[0] or KEY[1] strobe. The counter and the OPEN_CYC logic are absent.

Test Plan:
- Correct code: reset, CODE_LEN=3, DEF_CODE=16'h0010. Enter SW=0,1,0 with KEY[1] pulses -> unlocked=1, LED=8'hFF 3 cycles after the third press; tries=0.
- Wrong code / lockout: LOCKOUT_CYC=20, MAX_TRIES=3. Enter 0,2,0 three times -> LED[5:4]=1 then 2, then alarm=1, LED=8'h80. Press KEY[1] during lockout -> no change. Exactly 20 cycles later -> ENTRY, LED=8'h00.
- Reprogram: from OPEN, press KEY[1], then enter 5,5,5 -> ENTRY. Entering 0,1,0 fails (tries=1). Entering 5,5,5 -> OPEN.
- Abort and tie-break:
  - In PROGRAM after 2 digits, press KEY[0] -> OPEN; old code 0,1,0 still unlocks.
  - KEY[0] and KEY[1] falling in the same cycle in ENTRY with idx=2 -> idx=0, tries unchanged.
- Held key and async reset:
  - Hold KEY[1] low for 100 cycles -> exactly one digit is consumed.
  - Assert rst mid-PROGRAM, between clock edges -> outputs are 0 immediately and DEF_CODE is restored.
- With LOCK_TIMEOUT_EN, OPEN_CYC=30: idle in OPEN -> ENTRY after 30 cycles. A KEY[1] strobe at cycle 25 enters PROGRAM (no timeout occurs).
